// File: rtl/spu_adpcm_decoder.sv
// rtl/spu_adpcm_decoder.sv - per-voice PSX SPU ADPCM block fetcher and decoder
// Fetches one 8-halfword block, decodes 28 samples with shift/filter prediction and exports loop flags.
module spu_adpcm_decoder #(
    parameter int ADDR_W = 18
) (
    input  logic              sys_clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              clr_hist,
    input  logic              abort,
    input  logic [15:0]       block_addr,
    output logic              ram_rd,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic              ram_ack,
    input  logic [15:0]       ram_data,
    output logic [15:0]       sample_out,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              flag_end,
    output logic              flag_repeat,
    output logic              flag_start,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_DAT   = 3'd2,
        S_DEC   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         shift;
    logic [2:0]         filter;
    logic [15:0]        word_q;
    logic [2:0]         word_idx;
    logic [1:0]         nib_idx;
    logic               abort_pend;
    logic signed [15:0] old;
    logic signed [15:0] older;

    logic               accept_start;
    logic               abort_seen;
    logic               dec_fire;
    logic               last_nib;
    logic               last_word;

    logic [3:0]         nib;
    logic [3:0]         sh;
    logic signed [15:0] s_val;
    logic signed [24:0] f0;
    logic signed [24:0] f1;
    logic signed [24:0] acc;
    logic signed [24:0] y;
    logic [15:0]        dec_sample;

    // DONE blocks a same-cycle START so a voice cannot restart on its own completion pulse
    assign accept_start = (state == S_IDLE) && start && !abort && !done;
    assign abort_seen   = abort || abort_pend;
    assign dec_fire     = (state == S_DEC) && !abort && (!sample_valid || sample_ready);
    assign last_nib     = (nib_idx == 2'd3);
    assign last_word    = (word_idx == 3'd6);

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept_start) state_nxt = S_HDR;
            S_HDR:   if (ram_ack) state_nxt = abort_seen ? S_IDLE : S_DAT;
            S_DAT:   if (ram_ack) state_nxt = abort_seen ? S_IDLE : S_DEC;
            S_DEC: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (dec_fire && last_nib) begin
                    state_nxt = last_word ? S_DRAIN : S_DAT;
                end
            end
            S_DRAIN: if (abort || sample_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ram_rd = (state == S_HDR) || (state == S_DAT);
        busy   = (state != S_IDLE);
    end

    always_comb begin
        nib = 4'd0;
        case (nib_idx)
            2'd0: nib = word_q[3:0];
            2'd1: nib = word_q[7:4];
            2'd2: nib = word_q[11:8];
            2'd3: nib = word_q[15:12];
            default: nib = 4'd0;
        endcase
        sh    = (shift > 4'd12) ? 4'd9 : shift;
        s_val = $signed({nib, 12'h000}) >>> sh;
        case (filter)
            3'd0: begin f0 = 25'sd0;   f1 = 25'sd0;   end
            3'd1: begin f0 = 25'sd60;  f1 = 25'sd0;   end
            3'd2: begin f0 = 25'sd115; f1 = -25'sd52; end
            3'd3: begin f0 = 25'sd98;  f1 = -25'sd55; end
            default: begin f0 = 25'sd122; f1 = -25'sd60; end
        endcase
        acc = old * f0 + older * f1 + 25'sd32;
        y   = s_val + (acc >>> 6);
        if (y > 25'sd32767) begin
            dec_sample = 16'h7FFF;
        end else if (y < -25'sd32768) begin
            dec_sample = 16'h8000;
        end else begin
            dec_sample = y[15:0];
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_addr     <= '0;
            shift        <= 4'd0;
            filter       <= 3'd0;
            flag_end     <= 1'b0;
            flag_repeat  <= 1'b0;
            flag_start   <= 1'b0;
            word_q       <= 16'd0;
            word_idx     <= 3'd0;
            nib_idx      <= 2'd0;
            abort_pend   <= 1'b0;
            old          <= 16'sd0;
            older        <= 16'sd0;
            sample_out   <= 16'd0;
            sample_valid <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= (state == S_DRAIN) && !abort && sample_ready;

            case (state)
                S_IDLE: begin
                    if (accept_start) begin
                        ram_addr    <= ADDR_W'({block_addr, 2'b00});
                        flag_end    <= 1'b0;
                        flag_repeat <= 1'b0;
                        flag_start  <= 1'b0;
                        word_idx    <= 3'd0;
                        abort_pend  <= 1'b0;
                        if (clr_hist) begin
                            old   <= 16'sd0;
                            older <= 16'sd0;
                        end
                    end
                end
                S_HDR: begin
                    if (abort) abort_pend <= 1'b1;
                    if (ram_ack && !abort_seen) begin
                        shift       <= ram_data[3:0];
                        filter      <= ram_data[6:4];
                        flag_end    <= ram_data[8];
                        flag_repeat <= ram_data[9];
                        flag_start  <= ram_data[10];
                        ram_addr    <= ram_addr + ADDR_W'(1);
                    end
                end
                S_DAT: begin
                    if (abort) abort_pend <= 1'b1;
                    if (ram_ack && !abort_seen) begin
                        word_q  <= ram_data;
                        nib_idx <= 2'd0;
                    end
                end
                S_DEC: begin
                    if (dec_fire) begin
                        sample_out <= dec_sample;
                        older      <= old;
                        old        <= dec_sample;
                        nib_idx    <= nib_idx + 2'd1;
                        if (last_nib && !last_word) begin
                            word_idx <= word_idx + 3'd1;
                            ram_addr <= ram_addr + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase

            // key-off discards any sample still waiting downstream
            if (abort && (state != S_IDLE)) begin
                sample_valid <= 1'b0;
            end else if (dec_fire) begin
                sample_valid <= 1'b1;
            end else if (sample_ready) begin
                sample_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spu_adpcm_decoder.sv
// tb/tb_spu_adpcm_decoder.sv - self-checking bench for spu_adpcm_decoder
// Table-driven block decodes plus directed stall, flag, address, abort and reset sequences.
module tb_spu_adpcm_decoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        clr_hist;
    logic        abort;
    logic [15:0] block_addr;
    logic        ram_rd;
    logic [17:0] ram_addr;
    logic        ram_ack;
    logic [15:0] ram_data;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        sample_ready;
    logic        flag_end;
    logic        flag_repeat;
    logic        flag_start;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    spu_adpcm_decoder #(.ADDR_W(18)) dut (
        .sys_clk      (clk),
        .reset_n      (reset_n),
        .start        (start),
        .clr_hist     (clr_hist),
        .abort        (abort),
        .block_addr   (block_addr),
        .ram_rd       (ram_rd),
        .ram_addr     (ram_addr),
        .ram_ack      (ram_ack),
        .ram_data     (ram_data),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .flag_end     (flag_end),
        .flag_repeat  (flag_repeat),
        .flag_start   (flag_start),
        .busy         (busy),
        .done         (done)
    );

    typedef struct {
        logic [15:0]      hdr;
        logic [15:0]      word;
        logic             clr;
        int               nexp;
        logic [3:0][15:0] exp;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] blk [8];
    logic [17:0] base_hw = '0;
    logic [15:0] caps [$];
    logic [17:0] addrs [$];
    int          done_cnt = 0;
    logic        rand_ready = 1'b0;
    logic        ready_level = 1'b1;
    logic        rand_ack = 1'b0;
    int          fixed_delay = 0;
    int          cur_delay = 0;
    int          wait_cnt = 0;
    logic        withdrawn = 1'b0;
    logic        held = 1'b0;
    logic [15:0] held_val = 16'd0;
    vec_t        vec [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] hdr, input logic [15:0] word, input logic clr,
                                input int n, input logic [15:0] e0, input logic [15:0] e1,
                                input logic [15:0] e2, input logic [15:0] e3);
        vec_t v;
        v.hdr = hdr; v.word = word; v.clr = clr; v.nexp = n;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
        return v;
    endfunction

    // SPU RAM model: acks after cur_delay idle cycles, data picked by offset within the block
    initial begin
        ram_ack  = 1'b0;
        ram_data = 16'd0;
        forever begin
            @(negedge clk);
            if (ram_ack) begin
                ram_ack = 1'b0;
            end else if (ram_rd) begin
                if (wait_cnt >= cur_delay) begin
                    ram_ack  = 1'b1;
                    ram_data = blk[3'(ram_addr - base_hw)];
                    addrs.push_back(ram_addr);
                    wait_cnt = 0;
                    cur_delay = rand_ack ? int'($urandom_range(0, 5)) : fixed_delay;
                end else begin
                    wait_cnt++;
                end
            end else begin
                if (wait_cnt != 0) withdrawn = 1'b1;
                wait_cnt = 0;
            end
        end
    end

    // Downstream consumer: drives ready, captures accepted samples, checks stall stability
    initial begin
        sample_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            sample_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
            if (sample_valid && held) chk("stall_stable", {16'd0, sample_out}, {16'd0, held_val});
            if (sample_valid && sample_ready) begin
                caps.push_back(sample_out);
                held = 1'b0;
            end else if (sample_valid) begin
                held     = 1'b1;
                held_val = sample_out;
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic start_block(input logic [15:0] baddr, input logic [15:0] hdr,
                               input logic [15:0] word, input logic clr);
        blk[0] = hdr;
        for (int i = 1; i < 8; i++) blk[i] = word;
        base_hw = {baddr, 2'b00};
        caps.delete();
        addrs.delete();
        done_cnt   = 0;
        withdrawn  = 1'b0;
        block_addr = baddr;
        clr_hist   = clr;
        start      = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        clr_hist = 1'b0;
    endtask

    task automatic wait_block();
        int c = 0;
        while (done_cnt == 0 && c < 3000) begin
            @(negedge clk);
            c++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_valid(input string name);
        int c = 0;
        while (!sample_valid && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk(name, {31'd0, sample_valid}, 32'd1);
    endtask

    initial begin
        int c;
        reset_n = 1'b0; start = 1'b0; clr_hist = 1'b0; abort = 1'b0; block_addr = 16'd0;

        vec[0] = mk(16'h0000, 16'h4321, 1'b1, 4, 16'h1000, 16'h2000, 16'h3000, 16'h4000);
        vec[1] = mk(16'h0010, 16'h0000, 1'b0, 2, 16'h3C00, 16'h3840, 16'h0000, 16'h0000);
        vec[2] = mk(16'h0004, 16'h000F, 1'b1, 1, 16'hFF00, 16'h0000, 16'h0000, 16'h0000);
        vec[3] = mk(16'h000D, 16'h0001, 1'b1, 1, 16'h0008, 16'h0000, 16'h0000, 16'h0000);
        vec[4] = mk(16'h0000, 16'h0008, 1'b1, 1, 16'h8000, 16'h0000, 16'h0000, 16'h0000);
        vec[5] = mk(16'h0010, 16'h0077, 1'b1, 4, 16'h7000, 16'h7FFF, 16'h77FF, 16'h707F);
        vec[6] = mk(16'h0010, 16'h0099, 1'b1, 2, 16'h9000, 16'h8000, 16'h0000, 16'h0000);
        vec[7] = mk(16'h007C, 16'h0011, 1'b1, 4, 16'h0001, 16'h0003, 16'h0005, 16'h0007);

        repeat (3) @(negedge clk);
        chk("rst_ram_rd", {31'd0, ram_rd}, 32'd0);
        chk("rst_ram_addr", {14'd0, ram_addr}, 32'd0);
        chk("rst_sample", {15'd0, sample_valid, sample_out}, 32'd0);
        chk("rst_flags_busy_done", {27'd0, flag_end, flag_repeat, flag_start, busy, done}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int r = 0; r < 8; r++) begin
            start_block(16'h0040, vec[r].hdr, vec[r].word, vec[r].clr);
            wait_block();
            chk($sformatf("vec%0d_done_cnt", r), done_cnt, 1);
            chk($sformatf("vec%0d_n_samples", r), caps.size(), 28);
            chk($sformatf("vec%0d_busy", r), {31'd0, busy}, 32'd0);
            for (int k = 0; k < vec[r].nexp; k++)
                chk($sformatf("vec%0d_s%0d", r, k), {16'd0, caps[k]}, {16'd0, vec[r].exp[k]});
        end

        rand_ready = 1'b1; rand_ack = 1'b1; cur_delay = 3;
        start_block(16'h0040, 16'h0000, 16'h4321, 1'b1);
        wait_block();
        chk("stall_done_cnt", done_cnt, 1);
        chk("stall_n_samples", caps.size(), 28);
        for (int k = 0; k < 28; k++)
            chk($sformatf("stall_s%0d", k), {16'd0, caps[k]}, 32'h1000 * ((k % 4) + 1));
        rand_ready = 1'b0; rand_ack = 1'b0; fixed_delay = 0; cur_delay = 0;

        start_block(16'h1234, 16'h0700, 16'h0000, 1'b1);
        wait_block();
        chk("flags_set", {29'd0, flag_end, flag_repeat, flag_start}, 32'd7);
        chk("addr_count", addrs.size(), 8);
        for (int k = 0; k < 8; k++)
            chk($sformatf("addr%0d", k), {14'd0, addrs[k]}, 32'h048D0 + k);
        fixed_delay = 3; cur_delay = 3;
        start_block(16'h0040, 16'h0000, 16'h0000, 1'b1);
        chk("flags_cleared_on_start", {29'd0, flag_end, flag_repeat, flag_start}, 32'd0);
        chk("hdr_req", {13'd0, busy, ram_rd, ram_addr}, {13'd0, 1'b1, 1'b1, 18'h00100});
        wait_block();
        chk("delayed_done_cnt", done_cnt, 1);

        fixed_delay = 4; cur_delay = 4;
        start_block(16'h0080, 16'h0000, 16'h4321, 1'b1);
        c = 0;
        while (!(ram_rd && ram_addr == base_hw + 18'd1) && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("abort_dat_req_seen", {31'd0, ram_rd}, 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_rd_held", {30'd0, busy, ram_rd}, 32'd3);
        c = 0;
        while (busy && c < 100) begin
            @(negedge clk);
            c++;
        end
        repeat (2) @(negedge clk);
        chk("abort_dat_idle", {30'd0, busy, sample_valid}, 32'd0);
        chk("abort_dat_no_done", done_cnt, 0);
        chk("abort_dat_no_samples", caps.size(), 0);
        chk("abort_dat_not_withdrawn", {31'd0, withdrawn}, 32'd0);
        chk("abort_dat_acks", addrs.size(), 2);
        fixed_delay = 0; cur_delay = 0;

        ready_level = 1'b0;
        start_block(16'h0080, 16'h0000, 16'h4321, 1'b1);
        wait_valid("abort_dec_valid_seen");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_dec_idle", {30'd0, busy, sample_valid}, 32'd0);
        repeat (3) @(negedge clk);
        chk("abort_dec_no_done", done_cnt, 0);

        start_block(16'h0080, 16'h0700, 16'h4321, 1'b1);
        wait_valid("reset_dec_valid_seen");
        #2;
        reset_n = 1'b0;
        #1;
        chk("rstmid_ram", {13'd0, ram_rd, ram_addr}, 32'd0);
        chk("rstmid_sample", {15'd0, sample_valid, sample_out}, 32'd0);
        chk("rstmid_flags_busy_done", {27'd0, flag_end, flag_repeat, flag_start, busy, done}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        ready_level = 1'b1;
        @(negedge clk);
        start_block(16'h0040, 16'h0010, 16'h0000, 1'b0);
        wait_block();
        chk("post_reset_done_cnt", done_cnt, 1);
        chk("post_reset_hist_zero", {16'd0, caps[0]}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
